serial_minuend_restore: RTL

Bit-serial inverse of the team's two's-complement subtracter: given a difference word and the subtrahend that produced it, it reconstructs the minuend (a = diff + b) in two's complement. Both operands arrive LSB-first, one bit pair per clock, after a start strobe. Ripple addition is done with a single full-add cell and a registered carry. It sits downstream of the subtract datapath as a check/recovery stage and reports carry-out and signed overflow along with the result.

---
 rtl/serial_minuend_restore_if.sv | 36 +++
 rtl/serial_minuend_restore.sv | 131 +++++++++++++
 2 files changed

// File: rtl/serial_minuend_restore_if.sv
// ---------------------------------------------------------------------------
// serial_minuend_restore_if
//
// Groups the handshake and data signals of serial_minuend_restore.
//
//   start     master -> slave  begin an operation (honoured in IDLE/DONE)
//   diff_bit  master -> slave  serial difference bit, LSB first
//   sub_bit   master -> slave  serial subtrahend bit, LSB first
//   busy      slave -> master  high while operand bits are being sampled
//   done      slave -> master  one-cycle pulse, result/c_out/ovf just updated
//   result    slave -> master  reconstructed minuend (WIDTH bits)
//   c_out     slave -> master  unsigned carry out of the MSB
//   ovf       slave -> master  signed overflow of diff + sub
// ---------------------------------------------------------------------------
interface serial_minuend_restore_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             diff_bit;
   logic             sub_bit;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             c_out;
   logic             ovf;

   modport master (
      output start, diff_bit, sub_bit,
      input  busy, done, result, c_out, ovf
   );

   modport slave (
      input  start, diff_bit, sub_bit,
      output busy, done, result, c_out, ovf
   );
endinterface

// File: rtl/serial_minuend_restore.sv
// ---------------------------------------------------------------------------
// serial_minuend_restore
//
// Bit-serial reconstruction of a minuend from a difference word and the
// subtrahend that produced it: result = diff + sub (mod 2^WIDTH).  Operands
// arrive LSB first, one bit pair per clock, after a start strobe.  A single
// full-add cell with a registered carry does the ripple addition.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset (priority over everything)
//   bus  serial_minuend_restore_if.slave (start, diff_bit, sub_bit in;
//        busy, done, result, c_out, ovf out)
//
// Timing: start seen at edge T -> bit i sampled at edge T+1+i, busy high in
// cycles T+1..T+WIDTH, done (with result valid) in cycle T+WIDTH+1.
// ---------------------------------------------------------------------------
module serial_minuend_restore #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   serial_minuend_restore_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state_q,  state_d;
   logic             carry_q,  carry_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [WIDTH-1:0] shreg_q,  shreg_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             c_out_q,  c_out_d;
   logic             ovf_q,    ovf_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;

   // Full-add cell on the current bit pair and the registered carry.
   logic sum_bit;
   logic carry_next;

   assign sum_bit    = bus.diff_bit ^ bus.sub_bit ^ carry_q;
   assign carry_next = (bus.diff_bit & bus.sub_bit) |
                       ((bus.diff_bit ^ bus.sub_bit) & carry_q);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      state_d  = state_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      shreg_d  = shreg_q;
      result_d = result_q;
      c_out_d  = c_out_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = SHIFT;
               carry_d = 1'b0;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            // start is deliberately not looked at here: no restart mid-word.
            // Right shift with the new sum bit entering at the MSB, so the
            // first bit sampled ends up in bit 0 after WIDTH shifts.
            shreg_d = {sum_bit, shreg_q[WIDTH-1:1]};
            carry_d = carry_next;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               // This cycle carries the MSB pair: sign-based overflow is
               // formed from the live operand bits and the MSB sum.
               state_d  = DONE;
               result_d = shreg_d;
               c_out_d  = carry_next;
               ovf_d    = (bus.diff_bit == bus.sub_bit) &&
                          (sum_bit != bus.diff_bit);
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, decoded from the next state.
      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         shreg_q  <= '0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         shreg_q  <= shreg_d;
         result_q <= result_d;
         c_out_q  <= c_out_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.c_out  = c_out_q;
   assign bus.ovf    = ovf_q;

endmodule
